// File: rtl/reg_load_pkg.sv
// Shared types and constants for the destination register write scheduler.
package reg_load_pkg;

    localparam int unsigned DW   = 4;
    localparam int unsigned NREG = 3;

    // Scheduler FSM encoding; 2'd3 is illegal and falls back to IDLE.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_ACK   = 2'd2
    } state_e;

    localparam logic [NREG-1:0] PTR_RESET = NREG'(3'b100);

    // True when exactly one bit of a destination pointer is set.
    function automatic logic ptr_is_onehot(input logic [NREG-1:0] p);
        return (p != '0) && ((p & (p - NREG'(1))) == '0);
    endfunction

endpackage

// File: rtl/dest_ptr_ring.sv
// One-hot destination pointer: rotates S2 -> S0 -> S1 -> S2 on each advance.
module dest_ptr_ring
    import reg_load_pkg::*;
(
    input  logic            CLK,
    input  logic            RST,
    input  logic            ADV,
    output logic [NREG-1:0] PTR
);

    logic [NREG-1:0] ptr_q;
    logic [NREG-1:0] ptr_d;

    // Next pointer: rotate left on advance; a corrupted pointer snaps back to reset.
    always_comb begin
        ptr_d = ptr_q;
        if (ADV) begin
            ptr_d = {ptr_q[NREG-2:0], ptr_q[NREG-1]};
        end
        if (!ptr_is_onehot(ptr_q)) begin
            ptr_d = PTR_RESET;
        end
    end

    // Pointer register with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            ptr_q <= PTR_RESET;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign PTR = ptr_q;

endmodule

// File: rtl/reg_load_sched.sv
// Round-robin write scheduler for the 3-entry destination register bank.
module reg_load_sched
    import reg_load_pkg::*;
(
    input  logic            CLK,
    input  logic            RST,
    input  logic            REQ_A,
    input  logic [DW-1:0]   DATA_A,
    input  logic            REQ_B,
    input  logic [DW-1:0]   DATA_B,
    output logic            ACK_A,
    output logic            ACK_B,
    output logic            WE,
    output logic [NREG-1:0] WSEL,
    output logic [DW-1:0]   WDATA,
    output logic            BUSY
);

    state_e          state_q, state_d;
    logic            gnt_b_q, gnt_b_d;     // current grant belongs to B
    logic            last_b_q, last_b_d;   // last grant went to B
    logic [DW-1:0]   wdata_q, wdata_d;
    logic            we_q, we_d;
    logic            ack_a_q, ack_a_d;
    logic            ack_b_q, ack_b_d;
    logic            busy_q, busy_d;
    logic            pick_b;
    logic            gnt_req;
    logic            ptr_adv;

    // Pointer moves once per completed write, never on a reset cycle.
    assign ptr_adv = (state_q == ST_WRITE) && !RST;

    dest_ptr_ring u_ptr (
        .CLK (CLK),
        .RST (RST),
        .ADV (ptr_adv),
        .PTR (WSEL)
    );

    // Next-state, arbitration and registered-output decode.
    always_comb begin
        state_d  = state_q;
        gnt_b_d  = gnt_b_q;
        last_b_d = last_b_q;
        wdata_d  = wdata_q;
        pick_b   = REQ_B && (!REQ_A || !last_b_q);
        gnt_req  = gnt_b_q ? REQ_B : REQ_A;

        case (state_q)
            ST_IDLE: begin
                if (REQ_A || REQ_B) begin
                    gnt_b_d  = pick_b;
                    last_b_d = pick_b;
                    wdata_d  = pick_b ? DATA_B : DATA_A;
                    state_d  = ST_WRITE;
                end
            end
            ST_WRITE: begin
                state_d = ST_ACK;
            end
            ST_ACK: begin
                if (!gnt_req) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        we_d    = (state_d == ST_WRITE);
        ack_a_d = (state_d == ST_ACK) && !gnt_b_d;
        ack_b_d = (state_d == ST_ACK) && gnt_b_d;
        busy_d  = (state_d != ST_IDLE);
    end

    // State and output registers; reset dominates any request.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= ST_IDLE;
            gnt_b_q  <= 1'b0;
            last_b_q <= 1'b1;
            wdata_q  <= '0;
            we_q     <= 1'b0;
            ack_a_q  <= 1'b0;
            ack_b_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            gnt_b_q  <= gnt_b_d;
            last_b_q <= last_b_d;
            wdata_q  <= wdata_d;
            we_q     <= we_d;
            ack_a_q  <= ack_a_d;
            ack_b_q  <= ack_b_d;
            busy_q   <= busy_d;
        end
    end

    assign WE    = we_q;
    assign ACK_A = ack_a_q;
    assign ACK_B = ack_b_q;
    assign WDATA = wdata_q;
    assign BUSY  = busy_q;

endmodule

// File: tb/tb_reg_load_sched.sv
// Scoreboard bench for reg_load_sched: expected writes queued by stimulus, popped on WE.
module tb_reg_load_sched;

    logic       CLK = 1'b0;
    logic       RST;
    logic       REQ_A, REQ_B;
    logic [3:0] DATA_A, DATA_B;
    logic       ACK_A, ACK_B, WE, BUSY;
    logic [2:0] WSEL;
    logic [3:0] WDATA;

    typedef struct packed {
        logic [2:0] wsel;
        logic [3:0] wdata;
        logic       is_b;
    } exp_wr_t;

    exp_wr_t exp_q[$];
    int checks   = 0;
    int errors   = 0;
    int we_count = 0;
    logic ack_chk = 1'b0;
    logic ack_exp_b = 1'b0;

    reg_load_sched dut (
        .CLK   (CLK),
        .RST   (RST),
        .REQ_A (REQ_A),
        .DATA_A(DATA_A),
        .REQ_B (REQ_B),
        .DATA_B(DATA_B),
        .ACK_A (ACK_A),
        .ACK_B (ACK_B),
        .WE    (WE),
        .WSEL  (WSEL),
        .WDATA (WDATA),
        .BUSY  (BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h @%0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every WE pulse consumes one expected write; the following cycle shows its ACK.
    always @(negedge CLK) begin
        if (ack_chk) begin
            check("ack_a_after_we", 8'(ACK_A), 8'(!ack_exp_b));
            check("ack_b_after_we", 8'(ACK_B), 8'(ack_exp_b));
            ack_chk = 1'b0;
        end
        if (WE === 1'b1) begin
            exp_wr_t e;
            we_count++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_we: wsel %0b wdata %0h @%0t", WSEL, WDATA, $time);
            end else begin
                e = exp_q.pop_front();
                check("we_wsel", 8'(WSEL), 8'(e.wsel));
                check("we_wdata", 8'(WDATA), 8'(e.wdata));
                ack_chk   = !RST;
                ack_exp_b = e.is_b;
            end
        end
    end

    task automatic do_reset();
        @(posedge CLK); #1;
        RST = 1'b1; REQ_A = 1'b0; REQ_B = 1'b0;
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;
    endtask

    // Wait (bounded) at negedges for the selected ACK to be high.
    task automatic wait_ack(input logic is_b, input string name);
        for (int i = 0; i < 30; i++) begin
            @(negedge CLK);
            if ((is_b ? ACK_B : ACK_A) === 1'b1) return;
        end
        checks++;
        errors++;
        $display("FAIL %s: ack timeout got 0 expected 1 @%0t", name, $time);
    endtask

    // Full handshake for a single requester; caller is aligned just after a posedge.
    task automatic do_req(input logic is_b, input logic [3:0] d, input logic [2:0] wsel);
        exp_q.push_back('{wsel: wsel, wdata: d, is_b: is_b});
        if (is_b) begin DATA_B = d; REQ_B = 1'b1; end
        else      begin DATA_A = d; REQ_A = 1'b1; end
        wait_ack(is_b, "do_req");
        @(posedge CLK); #1;
        if (is_b) REQ_B = 1'b0; else REQ_A = 1'b0;
        @(posedge CLK); #1;
    endtask

    initial begin
        int base;
        RST = 1'b1; REQ_A = 1'b0; REQ_B = 1'b0; DATA_A = 4'h0; DATA_B = 4'h0;

        // Reset state.
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;
        @(negedge CLK);
        check("rst_wsel", 8'(WSEL), 8'h04);
        check("rst_we", 8'(WE), 8'h00);
        check("rst_ack_a", 8'(ACK_A), 8'h00);
        check("rst_ack_b", 8'(ACK_B), 8'h00);
        check("rst_busy", 8'(BUSY), 8'h00);
        check("rst_wdata", 8'(WDATA), 8'h00);

        // Single A write, with DATA_A changing after the grant.
        @(posedge CLK); #1;
        exp_q.push_back('{wsel: 3'b100, wdata: 4'hA, is_b: 1'b0});
        DATA_A = 4'hA; REQ_A = 1'b1;
        wait_ack(1'b0, "single_a");
        check("single_a_wsel_rot", 8'(WSEL), 8'h01);
        check("single_a_busy", 8'(BUSY), 8'h01);
        DATA_A = 4'h6;
        @(posedge CLK); #1 REQ_A = 1'b0;
        @(negedge CLK);
        check("single_a_ack_hold", 8'(ACK_A), 8'h01);
        check("single_a_wdata_hold", 8'(WDATA), 8'h0A);
        @(negedge CLK);
        check("single_a_ack_drop", 8'(ACK_A), 8'h00);
        check("single_a_idle", 8'(BUSY), 8'h00);

        // Tie after reset: A first, then B.
        do_reset();
        exp_q.push_back('{wsel: 3'b100, wdata: 4'h3, is_b: 1'b0});
        exp_q.push_back('{wsel: 3'b001, wdata: 4'h5, is_b: 1'b1});
        DATA_A = 4'h3; DATA_B = 4'h5; REQ_A = 1'b1; REQ_B = 1'b1;
        wait_ack(1'b0, "tie_a");
        @(posedge CLK); #1 REQ_A = 1'b0;
        wait_ack(1'b1, "tie_b");
        @(posedge CLK); #1 REQ_B = 1'b0;
        @(posedge CLK); #1;

        // Wrap: three B writes.
        do_reset();
        do_req(1'b1, 4'h1, 3'b100);
        do_req(1'b1, 4'h2, 3'b001);
        do_req(1'b1, 4'h4, 3'b010);
        @(negedge CLK);
        check("wrap_ptr", 8'(WSEL), 8'h04);

        // Reset asserted during the WRITE cycle.
        do_reset();
        base = we_count;
        exp_q.push_back('{wsel: 3'b100, wdata: 4'hC, is_b: 1'b0});
        DATA_A = 4'hC; REQ_A = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b1; REQ_A = 1'b0;
        @(posedge CLK); #1 RST = 1'b0;
        @(negedge CLK);
        check("midrst_busy", 8'(BUSY), 8'h00);
        check("midrst_wsel", 8'(WSEL), 8'h04);
        check("midrst_ack", 8'({ACK_A, ACK_B}), 8'h00);
        check("midrst_we", 8'(WE), 8'h00);
        repeat (4) @(negedge CLK);
        check("midrst_we_count", 8'(we_count - base), 8'h01);

        // Long hold of A while B waits.
        do_reset();
        exp_q.push_back('{wsel: 3'b100, wdata: 4'h7, is_b: 1'b0});
        exp_q.push_back('{wsel: 3'b001, wdata: 4'h9, is_b: 1'b1});
        DATA_A = 4'h7; DATA_B = 4'h9; REQ_A = 1'b1; REQ_B = 1'b1;
        wait_ack(1'b0, "hold_a");
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            check("hold_ack_a", 8'(ACK_A), 8'h01);
            check("hold_no_we", 8'(WE), 8'h00);
        end
        @(posedge CLK); #1 REQ_A = 1'b0;
        @(negedge CLK);
        check("hold_ack_still", 8'(ACK_A), 8'h01);
        @(negedge CLK);
        check("hold_idle", 8'(BUSY), 8'h00);
        check("hold_ack_a_drop", 8'(ACK_A), 8'h00);
        @(negedge CLK);
        check("hold_b_granted", 8'(WE), 8'h01);
        wait_ack(1'b1, "hold_b");
        @(posedge CLK); #1 REQ_B = 1'b0;
        repeat (3) @(posedge CLK);

        @(negedge CLK);
        check("scoreboard_empty", 8'(exp_q.size()), 8'h00);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
